// File: rtl/csr_file.sv
// Machine-mode CSR register file: CSR read/modify/write in MEM, 64-bit cycle/instret
// counters, and the trap-entry / mret updates to mstatus, mepc, mcause and mtval.
module csr_file #(
  parameter logic [31:0] MHARTID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_en_mem,
  input  logic [2:0]  csr_op_mem,
  input  logic [11:0] csr_addr_mem,
  input  logic [4:0]  rs1_addr_mem,
  input  logic [31:0] rs1_val_mem,
  input  logic        stall_mem,
  input  logic        instret_wb,
  input  logic        trap_wb,
  input  logic [31:0] trap_cause_wb,
  input  logic [31:0] trap_pc_wb,
  input  logic [31:0] trap_val_wb,
  input  logic        mret_wb,
  output logic [31:0] csr_rdata,
  output logic        illegal_csr,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
  localparam logic [31:0] MTVEC_INIT = MTVEC_RESET & ~32'h3;
  localparam logic [31:0] ALIGN_MASK = ~32'h3;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic        status_mie;
  logic        status_mpie;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  logic [31:0] src;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic [31:0] mstatus_val;
  logic        mapped;
  logic        wr_intent;
  logic        commit;

  logic        wr_mstatus;
  logic        wr_mie;
  logic        wr_mtvec;
  logic        wr_mscratch;
  logic        wr_mepc;
  logic        wr_mcause;
  logic        wr_mtval;
  logic        wr_mcycle;
  logic        wr_mcycleh;
  logic        wr_minstret;
  logic        wr_minstreth;

  assign src = csr_op_mem[2] ? {27'b0, rs1_addr_mem} : rs1_val_mem;

  // RW forms always write; set/clear forms only when they name a nonzero rs1/uimm.
  assign wr_intent = (csr_op_mem[1:0] == 2'b01) |
                     ((csr_op_mem[1:0] != 2'b00) & (rs1_addr_mem != 5'd0));

  assign mstatus_val = {19'b0, 2'b11, 3'b0, status_mpie, 3'b0, status_mie, 3'b0};

  always_comb begin
    mapped  = 1'b1;
    old_val = '0;
    case (csr_addr_mem)
      A_MSTATUS:               old_val = mstatus_val;
      A_MISA:                  old_val = MISA_VALUE;
      A_MIE:                   old_val = mie_q;
      A_MTVEC:                 old_val = mtvec_q;
      A_MSCRATCH:              old_val = mscratch_q;
      A_MEPC:                  old_val = mepc_q;
      A_MCAUSE:                old_val = mcause_q;
      A_MTVAL:                 old_val = mtval_q;
      A_MIP:                   old_val = '0;
      A_MCYCLE, A_CYCLE:       old_val = mcycle_q[31:0];
      A_MCYCLEH, A_CYCLEH:     old_val = mcycle_q[63:32];
      A_MINSTRET, A_INSTRET:   old_val = minstret_q[31:0];
      A_MINSTRETH, A_INSTRETH: old_val = minstret_q[63:32];
      A_MHARTID:               old_val = MHARTID;
      default:                 mapped  = 1'b0;
    endcase
  end

  // Address bits [11:10] == 2'b11 mark the read-only CSR space.
  assign illegal_csr = csr_en_mem &
                       (~mapped | (wr_intent & (csr_addr_mem[11:10] == 2'b11)));
  assign csr_rdata   = illegal_csr ? 32'h0 : old_val;

  always_comb begin
    new_val = old_val;
    case (csr_op_mem[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  assign commit = csr_en_mem & ~illegal_csr & ~stall_mem & ~trap_wb & wr_intent;

  assign wr_mstatus   = commit & (csr_addr_mem == A_MSTATUS);
  assign wr_mie       = commit & (csr_addr_mem == A_MIE);
  assign wr_mtvec     = commit & (csr_addr_mem == A_MTVEC);
  assign wr_mscratch  = commit & (csr_addr_mem == A_MSCRATCH);
  assign wr_mepc      = commit & (csr_addr_mem == A_MEPC);
  assign wr_mcause    = commit & (csr_addr_mem == A_MCAUSE);
  assign wr_mtval     = commit & (csr_addr_mem == A_MTVAL);
  assign wr_mcycle    = commit & (csr_addr_mem == A_MCYCLE);
  assign wr_mcycleh   = commit & (csr_addr_mem == A_MCYCLEH);
  assign wr_minstret  = commit & (csr_addr_mem == A_MINSTRET);
  assign wr_minstreth = commit & (csr_addr_mem == A_MINSTRETH);

  // mstatus: trap entry beats mret, which beats a software write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
    end else if (trap_wb) begin
      status_mpie <= status_mie;
      status_mie  <= 1'b0;
    end else if (mret_wb) begin
      status_mie  <= status_mpie;
      status_mpie <= 1'b1;
    end else if (wr_mstatus) begin
      status_mie  <= new_val[3];
      status_mpie <= new_val[7];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_wb) begin
      mepc_q   <= trap_pc_wb & ALIGN_MASK;
      mcause_q <= trap_cause_wb;
      mtval_q  <= trap_val_wb;
    end else begin
      if (wr_mepc)   mepc_q   <= new_val & ALIGN_MASK;
      if (wr_mcause) mcause_q <= new_val;
      if (wr_mtval)  mtval_q  <= new_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mie_q      <= '0;
      mtvec_q    <= MTVEC_INIT;
      mscratch_q <= '0;
    end else begin
      if (wr_mie)      mie_q      <= new_val;
      if (wr_mtvec)    mtvec_q    <= new_val & ALIGN_MASK;
      if (wr_mscratch) mscratch_q <= new_val;
    end
  end

  // A write to one half wins over the increment; carry across the halves is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcycle_q <= '0;
    end else if (wr_mcycle) begin
      mcycle_q[31:0] <= new_val;
    end else if (wr_mcycleh) begin
      mcycle_q <= {new_val, mcycle_q[31:0] + 32'd1};
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      minstret_q <= '0;
    end else if (wr_minstret) begin
      minstret_q[31:0] <= new_val;
    end else if (wr_minstreth) begin
      minstret_q <= {new_val, minstret_q[31:0] + {31'b0, instret_wb}};
    end else begin
      minstret_q <= minstret_q + {63'b0, instret_wb};
    end
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
  assign mie_o   = status_mie;

endmodule

// File: tb/tb_csr_file.sv
// Testbench for csr_file: directed vector table, hand-written trap/counter/stall
// sequences, then randomized traffic checked against a behavioural model.
module tb_csr_file;

  localparam logic [31:0] HART     = 32'h0000_0007;
  localparam logic [31:0] TVEC_RST = 32'h0000_0103;
  localparam logic [31:0] TVEC_EXP = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_en_mem;
  logic [2:0]  csr_op_mem;
  logic [11:0] csr_addr_mem;
  logic [4:0]  rs1_addr_mem;
  logic [31:0] rs1_val_mem;
  logic        stall_mem;
  logic        instret_wb;
  logic        trap_wb;
  logic [31:0] trap_cause_wb;
  logic [31:0] trap_pc_wb;
  logic [31:0] trap_val_wb;
  logic        mret_wb;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_o;

  int tests_run    = 0;
  int tests_failed = 0;

  csr_file #(.MHARTID(HART), .MTVEC_RESET(TVEC_RST)) dut (
    .clk(clk), .reset(reset),
    .csr_en_mem(csr_en_mem), .csr_op_mem(csr_op_mem), .csr_addr_mem(csr_addr_mem),
    .rs1_addr_mem(rs1_addr_mem), .rs1_val_mem(rs1_val_mem), .stall_mem(stall_mem),
    .instret_wb(instret_wb), .trap_wb(trap_wb), .trap_cause_wb(trap_cause_wb),
    .trap_pc_wb(trap_pc_wb), .trap_val_wb(trap_val_wb), .mret_wb(mret_wb),
    .csr_rdata(csr_rdata), .illegal_csr(illegal_csr),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
  );

  always #5 clk = ~clk;

  // Reference state: architectural fields held as plain values.
  logic        m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0;
    m_mie_reg = 0; m_mtvec = TVEC_RST & ~32'h3; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_cycle = 0; m_instret = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a, output bit mapped);
    mapped = 1;
    case (a)
      12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie_reg;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return 32'h0;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      12'hF14: return HART;
      default: begin mapped = 0; return 32'h0; end
    endcase
  endfunction

  function automatic bit model_wants_write(input logic [2:0] op, input logic [4:0] rs1);
    if (op == 3'b001 || op == 3'b101) return 1;
    if (op inside {3'b010, 3'b011, 3'b110, 3'b111}) return rs1 != 0;
    return 0;
  endfunction

  function automatic bit model_illegal();
    bit mapped;
    logic [31:0] v;
    v = model_read(csr_addr_mem, mapped);
    return csr_en_mem && (!mapped ||
           (model_wants_write(csr_op_mem, rs1_addr_mem) && csr_addr_mem[11:10] == 2'b11));
  endfunction

  function automatic logic [31:0] model_rdata();
    bit mapped;
    logic [31:0] v;
    v = model_read(csr_addr_mem, mapped);
    return model_illegal() ? 32'h0 : v;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_update();
    bit mapped, commit;
    logic [31:0] old, src, nv;
    logic [63:0] ncyc, ninst;
    logic om, ompie;
    old   = model_read(csr_addr_mem, mapped);
    om    = m_mie;
    ompie = m_mpie;
    src   = csr_op_mem[2] ? {27'b0, rs1_addr_mem} : rs1_val_mem;
    case (csr_op_mem[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = old;
    endcase
    commit = csr_en_mem && !model_illegal() && !stall_mem && !trap_wb &&
             model_wants_write(csr_op_mem, rs1_addr_mem);
    ncyc  = m_cycle + 64'd1;
    ninst = m_instret + (instret_wb ? 64'd1 : 64'd0);
    if (commit) begin
      case (csr_addr_mem)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie_reg = nv;
        12'h305: m_mtvec = nv & ~32'h3;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: ncyc = {m_cycle[63:32], nv};
        12'hB80: ncyc[63:32] = nv;
        12'hB02: ninst = {m_instret[63:32], nv};
        12'hB82: ninst[63:32] = nv;
        default: ;
      endcase
    end
    m_cycle   = ncyc;
    m_instret = ninst;
    if (mret_wb && !trap_wb) begin
      m_mie  = ompie;
      m_mpie = 1;
    end
    if (trap_wb) begin
      m_mpie   = om;
      m_mie    = 0;
      m_mepc   = trap_pc_wb & ~32'h3;
      m_mcause = trap_cause_wb;
      m_mtval  = trap_val_wb;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_update();
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [2:0] op, input logic [11:0] addr,
                               input logic [4:0] rs1, input logic [31:0] val, input logic stall);
    csr_en_mem   = en;
    csr_op_mem   = op;
    csr_addr_mem = addr;
    rs1_addr_mem = rs1;
    rs1_val_mem  = val;
    stall_mem    = stall;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic wbIdle();
    instret_wb = 0; trap_wb = 0; mret_wb = 0;
    trap_cause_wb = 0; trap_pc_wb = 0; trap_val_wb = 0;
  endtask

  typedef struct {
    logic        en;
    logic [2:0]  op;
    logic [11:0] addr;
    logic [4:0]  rs1;
    logic [31:0] val;
    logic [31:0] exp_rdata;
    logic        exp_ill;
    string       name;
  } vec_t;

  vec_t vecs[$];

  localparam logic [11:0] RAND_ADDRS [21] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
    12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14,
    12'h7C0, 12'h306, 12'hB01};
  localparam logic [2:0] RAND_OPS [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

  initial begin
    reset = 1;
    wbIdle();
    applyStimulus(0, 3'b010, 12'h300, 0, 0, 0);
    model_reset();
    tick();
    tick();
    reset = 0;

    applyStimulus(0, 3'b010, 12'h300, 0, 0, 0);
    checkOutput("reset_mtvec", mtvec_o, TVEC_EXP);
    checkOutput("reset_mepc", mepc_o, 32'h0);
    checkOutput("reset_mie", {31'b0, mie_o}, 32'h0);

    vecs.push_back('{1, 3'b010, 12'h300, 0, 32'h0,        32'h0000_1800, 0, "rd_mstatus"});
    vecs.push_back('{1, 3'b010, 12'h301, 0, 32'h0,        32'h4000_0100, 0, "rd_misa"});
    vecs.push_back('{1, 3'b010, 12'hF14, 0, 32'h0,        HART,          0, "rd_mhartid"});
    vecs.push_back('{1, 3'b001, 12'h340, 0, 32'hDEAD_BEEF, 32'h0,        0, "rw_mscratch"});
    vecs.push_back('{1, 3'b010, 12'h340, 0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, "rs0_mscratch"});
    vecs.push_back('{1, 3'b011, 12'h340, 0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, "rc0_mscratch"});
    vecs.push_back('{1, 3'b001, 12'hC00, 0, 32'h5,        32'h0,         1, "rw_cycle_ro"});
    vecs.push_back('{1, 3'b001, 12'h7C0, 0, 32'h5,        32'h0,         1, "rw_unmapped"});
    vecs.push_back('{1, 3'b110, 12'h306, 3, 32'h0,        32'h0,         1, "rsi_unmapped"});
    vecs.push_back('{1, 3'b001, 12'hF14, 0, 32'h1,        32'h0,         1, "rw_mhartid_ro"});
    vecs.push_back('{1, 3'b010, 12'h340, 0, 32'h0,        32'hDEAD_BEEF, 0, "rd_mscratch_kept"});
    vecs.push_back('{1, 3'b110, 12'h300, 8, 32'h0,        32'h0000_1800, 0, "rsi_mstatus"});
    vecs.push_back('{1, 3'b010, 12'h300, 0, 32'h0,        32'h0000_1808, 0, "rd_mstatus_mie"});
    vecs.push_back('{1, 3'b111, 12'h300, 8, 32'h0,        32'h0000_1808, 0, "rci_mstatus"});
    vecs.push_back('{1, 3'b010, 12'h300, 0, 32'h0,        32'h0000_1800, 0, "rd_mstatus_clr"});
    vecs.push_back('{1, 3'b010, 12'h300, 5, 32'h0000_FF88, 32'h0000_1800, 0, "rs_mstatus"});
    vecs.push_back('{1, 3'b010, 12'h300, 0, 32'h0,        32'h0000_1888, 0, "rd_mstatus_set"});
    vecs.push_back('{1, 3'b011, 12'h300, 5, 32'h0000_0080, 32'h0000_1888, 0, "rc_mstatus"});
    vecs.push_back('{1, 3'b010, 12'h300, 0, 32'h0,        32'h0000_1808, 0, "rd_mstatus_mpie0"});
    vecs.push_back('{1, 3'b001, 12'h301, 0, 32'h0,        32'h4000_0100, 0, "rw_misa"});
    vecs.push_back('{1, 3'b010, 12'h301, 0, 32'h0,        32'h4000_0100, 0, "rd_misa_kept"});
    vecs.push_back('{1, 3'b001, 12'h344, 0, 32'hFFFF_FFFF, 32'h0,        0, "rw_mip"});
    vecs.push_back('{1, 3'b010, 12'h344, 0, 32'h0,        32'h0,         0, "rd_mip"});
    vecs.push_back('{1, 3'b001, 12'h341, 0, 32'h0000_1237, 32'h0,        0, "rw_mepc"});
    vecs.push_back('{1, 3'b010, 12'h341, 0, 32'h0,        32'h0000_1234, 0, "rd_mepc_align"});
    vecs.push_back('{1, 3'b001, 12'h304, 0, 32'hA5A5_A5A5, 32'h0,        0, "rw_mie"});
    vecs.push_back('{1, 3'b010, 12'h304, 0, 32'h0,        32'hA5A5_A5A5, 0, "rd_mie"});
    vecs.push_back('{1, 3'b101, 12'h343, 31, 32'h0,       32'h0,         0, "rwi_mtval"});
    vecs.push_back('{1, 3'b010, 12'h343, 0, 32'h0,        32'h0000_001F, 0, "rd_mtval"});
    vecs.push_back('{0, 3'b001, 12'h7C0, 0, 32'h0,        32'h0,         0, "idle_unmapped"});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].op, vecs[i].addr, vecs[i].rs1, vecs[i].val, 0);
      checkOutput({vecs[i].name, "_rdata"}, csr_rdata, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, "_illegal"}, {31'b0, illegal_csr}, {31'b0, vecs[i].exp_ill});
      tick();
    end

    // Trap entry collides with a CSRRCI to mstatus; the CSR write must be dropped.
    trap_wb = 1; trap_pc_wb = 32'h0000_1236; trap_cause_wb = 32'h2; trap_val_wb = 32'h0ABC;
    applyStimulus(1, 3'b111, 12'h300, 8, 0, 0);
    checkOutput("pretrap_mie", {31'b0, mie_o}, 32'h1);
    tick();
    wbIdle();
    applyStimulus(1, 3'b010, 12'h300, 0, 0, 0);
    checkOutput("trap_mepc", mepc_o, 32'h0000_1234);
    checkOutput("trap_mie", {31'b0, mie_o}, 32'h0);
    checkOutput("trap_mstatus", csr_rdata, 32'h0000_1880);
    applyStimulus(1, 3'b010, 12'h342, 0, 0, 0);
    checkOutput("trap_mcause", csr_rdata, 32'h2);
    applyStimulus(1, 3'b010, 12'h343, 0, 0, 0);
    checkOutput("trap_mtval", csr_rdata, 32'h0ABC);
    mret_wb = 1;
    tick();
    wbIdle();
    applyStimulus(1, 3'b010, 12'h300, 0, 0, 0);
    checkOutput("mret_mie", {31'b0, mie_o}, 32'h1);
    checkOutput("mret_mstatus", csr_rdata, 32'h0000_1888);

    // mcycle low word wraps into mcycleh; minstret idle without retirements.
    applyStimulus(1, 3'b001, 12'hB00, 0, 32'hFFFF_FFFF, 0);
    tick();
    applyStimulus(1, 3'b010, 12'hB00, 0, 0, 0);
    checkOutput("mcycle_written", csr_rdata, 32'hFFFF_FFFF);
    applyStimulus(0, 3'b010, 12'hB00, 0, 0, 0);
    tick();
    tick();
    applyStimulus(1, 3'b010, 12'hB00, 0, 0, 0);
    checkOutput("mcycle_wrapped", csr_rdata, 32'h1);
    applyStimulus(1, 3'b010, 12'hB80, 0, 0, 0);
    checkOutput("mcycleh_carry", csr_rdata, 32'h1);
    applyStimulus(1, 3'b010, 12'hC00, 0, 0, 0);
    checkOutput("cycle_shadow", csr_rdata, 32'h1);
    checkOutput("cycle_shadow_legal", {31'b0, illegal_csr}, 32'h0);
    applyStimulus(1, 3'b010, 12'hC80, 0, 0, 0);
    checkOutput("cycleh_shadow", csr_rdata, 32'h1);
    applyStimulus(1, 3'b010, 12'hB02, 0, 0, 0);
    checkOutput("minstret_idle", csr_rdata, 32'h0);

    // A stalled CSRRW to mtvec commits exactly once, on release.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 3'b001, 12'h305, 0, 32'h0000_2001, 1);
      checkOutput($sformatf("stall_mtvec_%0d", c), mtvec_o, TVEC_EXP);
      checkOutput($sformatf("stall_rdata_%0d", c), csr_rdata, TVEC_EXP);
      tick();
    end
    applyStimulus(1, 3'b001, 12'h305, 0, 32'h0000_2001, 0);
    checkOutput("release_mtvec_pre", mtvec_o, TVEC_EXP);
    tick();
    applyStimulus(0, 3'b010, 12'h305, 0, 0, 0);
    checkOutput("release_mtvec", mtvec_o, 32'h0000_2000);
    tick();
    checkOutput("release_mtvec_hold", mtvec_o, 32'h0000_2000);

    // Asynchronous reset in the middle of a stall.
    applyStimulus(1, 3'b001, 12'h305, 0, 32'h0000_3000, 1);
    tick();
    #1;
    reset = 1;
    #1;
    checkOutput("midreset_mtvec", mtvec_o, TVEC_EXP);
    checkOutput("midreset_mepc", mepc_o, 32'h0);
    checkOutput("midreset_mie", {31'b0, mie_o}, 32'h0);
    applyStimulus(1, 3'b010, 12'h340, 0, 0, 0);
    checkOutput("midreset_mscratch", csr_rdata, 32'h0);
    tick();
    reset = 0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r;
      r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      instret_wb    = 1'($urandom);
      trap_wb       = ($urandom_range(0, 15) == 0);
      mret_wb       = ($urandom_range(0, 11) == 0);
      trap_cause_wb = $urandom;
      trap_pc_wb    = $urandom;
      trap_val_wb   = $urandom;
      applyStimulus(($urandom_range(0, 4) != 0), RAND_OPS[$urandom_range(0, 5)],
                    RAND_ADDRS[$urandom_range(0, 20)], r, $urandom,
                    ($urandom_range(0, 4) == 0));
      checkOutput($sformatf("rand%0d_rdata", n), csr_rdata, model_rdata());
      checkOutput($sformatf("rand%0d_illegal", n), {31'b0, illegal_csr},
                  {31'b0, model_illegal()});
      checkOutput($sformatf("rand%0d_mtvec", n), mtvec_o, m_mtvec);
      checkOutput($sformatf("rand%0d_mepc", n), mepc_o, m_mepc);
      checkOutput($sformatf("rand%0d_mie", n), {31'b0, mie_o}, {31'b0, m_mie});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR register file for the RV32 core. It is the responder for CSR instructions in the MEM stage. It takes the forwarded RS1 operand or the immediate, returns the old CSR value for rd, and commits writes on the clock edge. It also owns the 64-bit cycle/instret counters and the trap-entry/mret state updates signalled from WB, and drives mtvec/mepc to the PC-select logic.

## Interface
Parameters:
- MHARTID, 32'd0, value returned for mhartid.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (bits [1:0] forced 0).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- csr_en_mem  input  1  MEM-stage instruction is a CSR op.
- csr_op_mem  input  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- csr_addr_mem  input  12  CSR address.
- rs1_addr_mem  input  5  rs1 field; also the uimm for the I-forms.
- rs1_val_mem  input  32  forwarded RS1 value.
- stall_mem  input  1  MEM held; suppresses commit.
- instret_wb  input  1  one instruction retired this cycle.
- trap_wb  input  1  take trap this cycle.
- trap_cause_wb  input  32  mcause value for the trap.
- trap_pc_wb  input  32  faulting PC.
- trap_val_wb  input  32  mtval value.
- mret_wb  input  1  mret retiring.
- csr_rdata  output  32  old CSR value; combinational from csr_addr_mem.
- illegal_csr  output  1  combinational illegal-access flag.
- mtvec_o  output  32  current mtvec.
- mepc_o  output  32  current mepc.
- mie_o  output  1  mstatus.MIE.

## Operation
- Operand: src = csr_op_mem[2] ? {27'b0, rs1_addr_mem} : rs1_val_mem.
- New value: RW: src. RS: old | src. RC: old & ~src.
- Write intent: RW/RWI always. RS/RC/RSI/RCI only when rs1_addr_mem != 0.
- Read intent: always.
- Register map:
  - mstatus 0x300: MIE[3], MPIE[7], MPP[12:11] hardwired 2'b11. Other bits read 0 and ignore writes.
  - misa 0x301: read-only 32'h4000_0100.
  - mie 0x304: read/write.
  - mtvec 0x305: bits [1:0] read 0.
  - mscratch 0x340: read/write.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342: read/write.
  - mtval 0x343: read/write.
  - mip 0x344: reads 0, writes ignored.
  - mcycle 0xB00 / mcycleh 0xB80, minstret 0xB02 / minstreth 0xB82: read/write.
  - cycle 0xC00/0xC80, instret 0xC02/0xC82: read-only shadows.
  - mhartid 0xF14: read-only.
- illegal_csr = csr_en_mem & (unmapped address | (write intent & csr_addr_mem[11:10]==2'b11)). When illegal, csr_rdata = 0 and no state changes.
- Commit enable: csr_en_mem & ~illegal_csr & ~stall_mem & ~trap_wb & write intent.
- Counters:
  - mcycle (64-bit) increments every cycle.
  - minstret (64-bit) increments when instret_wb.
  - Carry from the low word into the high word; 64-bit wrap to 0.
  - A committed write to one half replaces that half that cycle. The other half keeps its old value with no carry applied.
- Trap entry (trap_wb): mepc <= trap_pc_wb & ~3, mcause <= trap_cause_wb, mtval <= trap_val_wb, MPIE <= MIE, MIE <= 0.
- mret_wb: MIE <= MPIE, MPIE <= 1.
- Priority: trap_wb > mret_wb > CSR commit. The losing mstatus/mepc updates are dropped. Counter increments are unaffected except by a same-half write.

## Timing
- Reset (async):
  - mstatus = 32'h0000_1800; mtvec = MTVEC_RESET & ~3.
  - All other writable CSRs and both counters = 0.
  - mtvec_o = MTVEC_RESET & ~3, mepc_o = 0, mie_o = 0.
- csr_rdata and illegal_csr are zero-latency combinational. They reflect pre-edge state, so a read of mcycle returns the count before this cycle's increment.
- Writes are visible on csr_rdata, mtvec_o and mepc_o the cycle after commit. There is no internal bypass.
- While stall_mem is high, the same instruction is re-presented and commits only on the first non-stalled cycle. The RS/RC read value is recomputed each cycle from live state.
- Reset asserted mid-operation aborts any pending commit. State returns to reset values in the same cycle.

## Test plan
- Reset, then read 0x300 → 0x0000_1800. Read 0x301 → 0x4000_0100. Read 0xF14 → MHARTID.
- CSRRW 0x340 with rs1_val=0xDEAD_BEEF, then CSRRS 0x340 with rs1=x0 → second read 0xDEAD_BEEF, illegal_csr=0, no write.
- CSRRSI 0x300 uimm=8 → MIE=1. Then trap_wb with trap_pc=0x0000_1236 and CSRRCI 0x300 in the same cycle → mepc=0x1234, MIE=0, MPIE=1; CSRRCI dropped. Then mret_wb → MIE=1.
- Write mcycle=0xFFFF_FFFF, free-run 2 cycles → mcycle=0x0000_0001, mcycleh incremented by 1. minstret unchanged without instret_wb.
- CSRRW to 0xC00, or to unmapped 0x7C0 → illegal_csr=1, csr_rdata=0, no state change. CSRRS 0xC00 with rs1=x0 → legal read.
- CSRRW 0x305 with stall_mem high for 3 cycles, then low → mtvec unchanged during the stall, updated once after release. Assert reset mid-stall → mtvec=MTVEC_RESET.
